// File: rtl/uart_cmd_ctrl_if.sv
// rtl/uart_cmd_ctrl_if.sv - byte stream in, held command and payload read port out
interface uart_cmd_ctrl_if #(
  parameter int MAX_LEN = 16
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int AW = $clog2(MAX_LEN);

  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [7:0]    cmd_opcode;
  logic [LW-1:0] cmd_len;
  logic [AW-1:0] pl_addr;
  logic [7:0]    pl_data;

  modport master (
    output rx_data, rx_valid, cmd_ready, pl_addr,
    input  cmd_valid, cmd_opcode, cmd_len, pl_data
  );

  modport slave (
    input  rx_data, rx_valid, cmd_ready, pl_addr,
    output cmd_valid, cmd_opcode, cmd_len, pl_data
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - framed command decoder (SOF/OPC/LEN/PAYLOAD/CHK) behind uart_rx
module uart_cmd_ctrl #(
  parameter int         CLOCK_HZ      = 25_000_000,
  parameter int         BAUD          = 115_200,
  parameter int         MAX_LEN       = 16,
  parameter int         TIMEOUT_BYTES = 4,
  parameter logic [7:0] SOF           = 8'hA5
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_cmd_ctrl_if.slave bus,
  output logic           err_chk,
  output logic           err_len,
  output logic           err_timeout,
  output logic           err_overflow,
  output logic [7:0]     drop_cnt
);
  localparam int LW        = $clog2(MAX_LEN + 1);
  localparam int AW        = $clog2(MAX_LEN);
  localparam int DEPTH     = 1 << AW;
  localparam int TO_CYCLES = TIMEOUT_BYTES * 10 * (CLOCK_HZ / BAUD);
  localparam int TW        = $clog2(TO_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_OPC, ST_LEN, ST_PAYLOAD, ST_CHK, ST_HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    opcode_q, opcode_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [7:0]    chk_q, chk_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;
  logic [7:0]    pl_buf_q [DEPTH];
  logic [7:0]    pl_buf_d [DEPTH];
  logic          err_chk_q, err_chk_d;
  logic          err_len_q, err_len_d;
  logic          err_timeout_q, err_timeout_d;
  logic          err_overflow_q, err_overflow_d;

  logic in_frame, handshake, to_expire, len_bad, chk_bad, drop, last_pl;

  always_comb begin
    in_frame  = (state_q == ST_OPC) || (state_q == ST_LEN) ||
                (state_q == ST_PAYLOAD) || (state_q == ST_CHK);
    handshake = (state_q == ST_HOLD) && bus.cmd_ready;
    // A byte arriving in the expiry cycle takes precedence over the timeout.
    to_expire = in_frame && !bus.rx_valid && (to_cnt_q == TW'(TO_CYCLES - 1));
    len_bad   = bus.rx_valid && (state_q == ST_LEN) && (int'(bus.rx_data) > MAX_LEN);
    chk_bad   = bus.rx_valid && (state_q == ST_CHK) && (bus.rx_data != chk_q);
    drop      = bus.rx_valid && (state_q == ST_HOLD) && !bus.cmd_ready;
    last_pl   = ((idx_q + LW'(1)) == len_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (to_expire) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    if (bus.rx_valid && bus.rx_data == SOF) state_d = ST_OPC;
        ST_OPC:     if (bus.rx_valid) state_d = ST_LEN;
        ST_LEN: begin
          if (bus.rx_valid) begin
            if (len_bad)                 state_d = ST_IDLE;
            else if (bus.rx_data == 8'd0) state_d = ST_CHK;
            else                          state_d = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: if (bus.rx_valid && last_pl) state_d = ST_CHK;
        ST_CHK:     if (bus.rx_valid) state_d = chk_bad ? ST_IDLE : ST_HOLD;
        ST_HOLD: begin
          // The handshake cycle doubles as an IDLE cycle for any incoming byte.
          if (handshake)
            state_d = (bus.rx_valid && bus.rx_data == SOF) ? ST_OPC : ST_IDLE;
        end
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    opcode_d       = opcode_q;
    len_d          = len_q;
    idx_d          = idx_q;
    chk_d          = chk_q;
    pl_buf_d       = pl_buf_q;
    drop_cnt_d     = drop_cnt_q;
    to_cnt_d       = (in_frame && !bus.rx_valid && !to_expire) ? to_cnt_q + TW'(1) : '0;
    err_chk_d      = chk_bad;
    err_len_d      = len_bad;
    err_timeout_d  = to_expire;
    err_overflow_d = drop;
    if (bus.rx_valid) begin
      case (state_q)
        ST_OPC: begin
          opcode_d = bus.rx_data;
          chk_d    = bus.rx_data;
        end
        ST_LEN: begin
          if (!len_bad) begin
            len_d = bus.rx_data[LW-1:0];
            chk_d = chk_q ^ bus.rx_data;
            idx_d = '0;
          end
        end
        ST_PAYLOAD: begin
          pl_buf_d[idx_q[AW-1:0]] = bus.rx_data;
          chk_d                   = chk_q ^ bus.rx_data;
          idx_d                   = idx_q + LW'(1);
        end
        ST_HOLD: begin
          if (drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q       <= '0;
      len_q          <= '0;
      idx_q          <= '0;
      chk_q          <= '0;
      to_cnt_q       <= '0;
      drop_cnt_q     <= '0;
      pl_buf_q       <= '{default: '0};
      err_chk_q      <= 1'b0;
      err_len_q      <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      opcode_q       <= opcode_d;
      len_q          <= len_d;
      idx_q          <= idx_d;
      chk_q          <= chk_d;
      to_cnt_q       <= to_cnt_d;
      drop_cnt_q     <= drop_cnt_d;
      pl_buf_q       <= pl_buf_d;
      err_chk_q      <= err_chk_d;
      err_len_q      <= err_len_d;
      err_timeout_q  <= err_timeout_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  always_comb begin
    bus.cmd_valid  = (state_q == ST_HOLD);
    bus.cmd_opcode = opcode_q;
    bus.cmd_len    = len_q;
    bus.pl_data    = pl_buf_q[bus.pl_addr];
    err_chk        = err_chk_q;
    err_len        = err_len_q;
    err_timeout    = err_timeout_q;
    err_overflow   = err_overflow_q;
    drop_cnt       = drop_cnt_q;
  end
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - directed frame vectors against uart_cmd_ctrl
module tb_uart_cmd_ctrl;
  logic       clk;
  logic       rst_n;
  logic       err_chk, err_len, err_timeout, err_overflow;
  logic [7:0] drop_cnt;
  int checks = 0;
  int errors = 0;
  int n_chk = 0, n_len = 0, n_to = 0, n_ovf = 0;

  uart_cmd_ctrl_if #(.MAX_LEN(16)) bus ();

  uart_cmd_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .err_chk      (err_chk),
    .err_len      (err_len),
    .err_timeout  (err_timeout),
    .err_overflow (err_overflow),
    .drop_cnt     (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err_chk)      n_chk++;
    if (err_len)      n_len++;
    if (err_timeout)  n_to++;
    if (err_overflow) n_ovf++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] s []);
    foreach (s[i]) send_byte(s[i]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept();
    bus.cmd_ready = 1'b1;
    tick();
    bus.cmd_ready = 1'b0;
  endtask

  task automatic check_pl(input string tag, input logic [3:0] a, input logic [7:0] exp);
    bus.pl_addr = a;
    #1;
    check(tag, {24'd0, bus.pl_data}, {24'd0, exp});
  endtask

  task automatic check_cmd(input string tag, input logic [7:0] opc, input logic [4:0] len);
    check({tag, "_valid"},  {31'd0, bus.cmd_valid}, 32'd1);
    check({tag, "_opcode"}, {24'd0, bus.cmd_opcode}, {24'd0, opc});
    check({tag, "_len"},    {27'd0, bus.cmd_len}, {27'd0, len});
  endtask

  initial begin
    int base, k;
    rst_n         = 1'b0;
    bus.rx_data   = 8'h00;
    bus.rx_valid  = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.pl_addr   = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_valid", {31'd0, bus.cmd_valid}, 32'd0);
    check("rst_opcode", {24'd0, bus.cmd_opcode}, 32'd0);
    check("rst_len", {27'd0, bus.cmd_len}, 32'd0);
    check("rst_pl", {24'd0, bus.pl_data}, 32'd0);
    check("rst_errs", {28'd0, err_chk, err_len, err_timeout, err_overflow}, 32'd0);
    check("rst_drop", {24'd0, drop_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1: good frame, checksum 10^02^01^02 = 11
    send_seq('{8'hA5, 8'h10, 8'h02, 8'h01, 8'h02, 8'h11});
    check_cmd("t1", 8'h10, 5'd2);
    check_pl("t1_pl0", 4'd0, 8'h01);
    check_pl("t1_pl1", 4'd1, 8'h02);
    accept();
    check("t1_after_hs", {31'd0, bus.cmd_valid}, 32'd0);

    // 2: bad checksum then good frame, 30^01^7E = 4F
    base = n_chk;
    send_seq('{8'hA5, 8'h10, 8'h02, 8'h01, 8'h02, 8'h12});
    check("t2_err_chk", {31'd0, err_chk}, 32'd1);
    check("t2_no_valid", {31'd0, bus.cmd_valid}, 32'd0);
    tick();
    check("t2_chk_pulses", n_chk - base, 32'd1);
    send_seq('{8'hA5, 8'h30, 8'h01, 8'h7E, 8'h4F});
    check_cmd("t2", 8'h30, 5'd1);
    check_pl("t2_pl0", 4'd0, 8'h7E);
    accept();

    // 3: LEN 17 rejected, then zero-length frame
    base = n_len;
    send_seq('{8'hA5, 8'h10, 8'h11});
    check("t3_err_len", {31'd0, err_len}, 32'd1);
    tick();
    check("t3_len_pulses", n_len - base, 32'd1);
    send_seq('{8'hA5, 8'h20, 8'h00, 8'h20});
    check_cmd("t3", 8'h20, 5'd0);
    accept();

    // 4: timeout exactly 8680 cycles after the opcode strobe
    base = n_to;
    send_seq('{8'hA5, 8'h10});
    k = 0;
    while (!err_timeout && k < 9000) begin
      tick();
      k++;
    end
    check("t4_to_latency", k, 32'd8680);
    tick();
    check("t4_to_pulses", n_to - base, 32'd1);
    base = n_chk + n_len + n_to + n_ovf;
    send_seq('{8'h3C, 8'h5A});
    send_seq('{8'hA5, 8'h40, 8'h01, 8'h55, 8'h14});
    check_cmd("t4", 8'h40, 5'd1);
    check_pl("t4_pl0", 4'd0, 8'h55);
    check("t4_no_errs", n_chk + n_len + n_to + n_ovf - base, 32'd0);
    accept();

    // 5: overflow while holding; SOF on the handshake cycle starts a frame
    send_seq('{8'hA5, 8'h10, 8'h02, 8'h01, 8'h02, 8'h11});
    base = n_ovf;
    send_seq('{8'hA5, 8'h50, 8'h02, 8'hAA, 8'hBB, 8'h43});
    tick();
    check("t5_ovf_pulses", n_ovf - base, 32'd6);
    check("t5_drop_cnt", {24'd0, drop_cnt}, 32'd6);
    check_cmd("t5_held", 8'h10, 5'd2);
    check_pl("t5_pl0", 4'd0, 8'h01);
    check_pl("t5_pl1", 4'd1, 8'h02);
    bus.cmd_ready = 1'b1;
    send_byte(8'hA5);
    bus.cmd_ready = 1'b0;
    check("t5_hs_valid", {31'd0, bus.cmd_valid}, 32'd0);
    check("t5_hs_no_drop", {24'd0, drop_cnt}, 32'd6);
    send_seq('{8'h60, 8'h01, 8'h33, 8'h52});
    check_cmd("t5_new", 8'h60, 5'd1);
    check_pl("t5_new_pl0", 4'd0, 8'h33);
    accept();

    // 6: async reset mid-payload, then a full frame, then saturating drops
    send_seq('{8'hA5, 8'h70, 8'h03, 8'h11, 8'h22});
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", {31'd0, bus.cmd_valid}, 32'd0);
    check("t6_rst_opcode", {24'd0, bus.cmd_opcode}, 32'd0);
    check("t6_rst_len", {27'd0, bus.cmd_len}, 32'd0);
    check_pl("t6_rst_pl0", 4'd0, 8'h00);
    check("t6_rst_drop", {24'd0, drop_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    send_seq('{8'hA5, 8'h70, 8'h03, 8'h11, 8'h22, 8'h33, 8'h73});
    check_cmd("t6", 8'h70, 5'd3);
    check_pl("t6_pl0", 4'd0, 8'h11);
    check_pl("t6_pl1", 4'd1, 8'h22);
    check_pl("t6_pl2", 4'd2, 8'h33);
    base = n_ovf;
    for (int i = 0; i < 300; i++) send_byte(8'h00);
    tick();
    check("t6_drop_sat", {24'd0, drop_cnt}, 32'd255);
    check("t6_ovf_pulses", n_ovf - base, 32'd300);
    accept();
    check("t6_final_valid", {31'd0, bus.cmd_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
